// File: rtl/instruction_fetch_pkg.sv
// Shared definitions for the instruction fetch unit: NOP encoding, fetch FSM
// states and the default sequential PC increment.
package instruction_fetch_pkg;

  localparam logic [31:0] NOP_INSTR     = 32'h0000_0013;
  localparam int unsigned FETCH_PC_STEP = 4;

  typedef enum logic [1:0] {
    FETCH_IDLE = 2'd0,
    FETCH_RUN  = 2'd1,
    FETCH_HALT = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/fetch_skid_reg.sv
// Output register holding one fetched instruction and its PC for decode.
// Latency: captures on the load edge, so out_valid rises one edge after load.
// Backpressure: holds contents while out_valid && !out_ready; flush wins over load.
module fetch_skid_reg
  import instruction_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        flush,
  input  logic [31:0] in_instr,
  input  logic [31:0] in_pc,
  input  logic        out_ready,
  output logic        out_valid,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc
);

  // Valid bit: flush drops the wrong-path word, load refills, a transfer without refill empties.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (load) begin
      out_valid <= 1'b1;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Payload only changes on a load; it keeps its last value when invalid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_instr <= NOP_INSTR;
      out_pc    <= RESET_PC;
    end else if (load && !flush) begin
      out_instr <= in_instr;
      out_pc    <= in_pc;
    end
  end

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch: drives ROM address from the PC, registers one word per cycle to decode.
// Latency: one edge from pc to out_valid; sustains one instruction per cycle.
// Backpressure: pc and output register hold while out_valid && !out_ready; redirect flushes.
module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned PC_STEP  = FETCH_PC_STEP
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  output logic [31:0] rom_addr,
  input  logic [31:0] rom_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic        fault,
  output logic [31:0] fetch_count
);

  fetch_state_t state, state_next;
  logic [31:0]  pc, pc_next;
  logic         load, flush, fault_set;
  logic         misaligned;

  assign rom_addr   = pc;
  assign misaligned = (redirect_pc[1:0] != 2'b00);

  // Next-state, PC and output-register control; redirect takes priority over load.
  always_comb begin
    state_next = state;
    pc_next    = pc;
    load       = 1'b0;
    flush      = 1'b0;
    fault_set  = 1'b0;
    case (state)
      FETCH_IDLE: begin
        if (redirect_valid && misaligned) begin
          fault_set  = 1'b1;
          flush      = 1'b1;
          state_next = FETCH_HALT;
        end else begin
          if (redirect_valid) begin
            pc_next = redirect_pc;
            flush   = 1'b1;
          end
          if (enable) state_next = FETCH_RUN;
        end
      end
      FETCH_RUN: begin
        if (redirect_valid && misaligned) begin
          fault_set  = 1'b1;
          flush      = 1'b1;
          state_next = FETCH_HALT;
        end else if (redirect_valid) begin
          pc_next    = redirect_pc;
          flush      = 1'b1;
          state_next = enable ? FETCH_RUN : FETCH_IDLE;
        end else if (!enable) begin
          state_next = FETCH_IDLE;
        end else if (!out_valid || out_ready) begin
          load    = 1'b1;
          pc_next = pc + 32'(PC_STEP);
        end
      end
      FETCH_HALT: begin
        state_next = FETCH_HALT;
      end
      default: begin
        state_next = FETCH_IDLE;
      end
    endcase
  end

  // State and PC registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= FETCH_IDLE;
      pc    <= RESET_PC;
    end else begin
      state <= state_next;
      pc    <= pc_next;
    end
  end

  // Sticky fault flag and handshake counter (counts even on a flushing edge).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fault       <= 1'b0;
      fetch_count <= 32'd0;
    end else begin
      if (fault_set) fault <= 1'b1;
      if (out_valid && out_ready) fetch_count <= fetch_count + 32'd1;
    end
  end

  fetch_skid_reg #(
    .RESET_PC (RESET_PC)
  ) u_skid (
    .clk       (clk),
    .rst       (reset),
    .load      (load),
    .flush     (flush),
    .in_instr  (rom_data),
    .in_pc     (pc),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_instr (out_instr),
    .out_pc    (out_pc)
  );

endmodule
